scale_coord_gen: RTL and testbench

//   Upstream stage of the interpolation-coefficient pipeline in the scaler.

---
 rtl/scale_coord_gen.sv | 197 +++++++++++++++++++
 tb/tb_scale_coord_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/scale_coord_gen.sv
// Output-raster walker for the scaler: maps each output pixel to a source
// coordinate (integer index + fractional phase) with edge clamping.
module scale_coord_gen #(
  parameter int INT_BITS  = 12,
  parameter int FRAC_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [INT_BITS+FRAC_BITS-1:0] step_x,
  input  logic [INT_BITS+FRAC_BITS-1:0] step_y,
  input  logic [INT_BITS-1:0]           src_w,
  input  logic [INT_BITS-1:0]           src_h,
  input  logic [INT_BITS-1:0]           out_w,
  input  logic [INT_BITS-1:0]           out_h,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_BITS-1:0]           x_int,
  output logic [FRAC_BITS-1:0]          x_frac,
  output logic [INT_BITS-1:0]           y_int,
  output logic [FRAC_BITS-1:0]          y_frac,
  output logic                          sol,
  output logic                          eol,
  output logic                          eof,
  output logic                          done
);

  localparam int STEP_W = INT_BITS + FRAC_BITS;
  localparam int ACC_W  = 40;
  localparam int IP_W   = ACC_W - FRAC_BITS;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_x_q, step_x_d, step_y_q, step_y_d;
  logic [INT_BITS-1:0] src_w_q, src_w_d, src_h_q, src_h_d;
  logic [INT_BITS-1:0] out_w_q, out_w_d, out_h_q, out_h_d;
  logic [ACC_W-1:0]    acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [INT_BITS-1:0] col_q, col_d, line_q, line_d;

  logic                 valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic                 sol_q, sol_d, eol_q, eol_d, eof_q, eof_d;
  logic [INT_BITS-1:0]  x_int_q, x_int_d, y_int_q, y_int_d;
  logic [FRAC_BITS-1:0] x_frac_q, x_frac_d, y_frac_q, y_frac_d;

  logic accept;
  logic launch;
  logic [STEP_W-1:0] x_coord, y_coord;

  assign accept = valid_q & out_ready;
  assign launch = (state_q == IDLE) & start;

  // Index at or beyond the last source sample pins to the edge with zero phase,
  // so the +1 neighbour fetch never leaves the source image.
  function automatic logic [STEP_W-1:0] clamp_coord(input logic [ACC_W-1:0]    acc,
                                                    input logic [INT_BITS-1:0] size);
    logic [IP_W-1:0] ip;
    logic [IP_W-1:0] lim;
    ip  = acc[ACC_W-1:FRAC_BITS];
    lim = IP_W'(size) - IP_W'(1);
    if (size == '0)
      return '0;
    else if (ip >= lim)
      return {size - INT_BITS'(1), {FRAC_BITS{1'b0}}};
    else
      return {ip[INT_BITS-1:0], acc[FRAC_BITS-1:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (out_w == '0 || out_h == '0) ? FIN : RUN;
      RUN:     if (accept && eof_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame config, accumulators and raster counters.
  always_comb begin
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    src_w_d  = src_w_q;
    src_h_d  = src_h_q;
    out_w_d  = out_w_q;
    out_h_d  = out_h_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    col_d    = col_q;
    line_d   = line_q;
    if (launch) begin
      step_x_d = step_x;
      step_y_d = step_y;
      src_w_d  = src_w;
      src_h_d  = src_h;
      out_w_d  = out_w;
      out_h_d  = out_h;
      acc_x_d  = '0;
      acc_y_d  = '0;
      col_d    = '0;
      line_d   = '0;
    end else if (accept && !eof_q) begin
      if (eol_q) begin
        acc_x_d = '0;
        col_d   = '0;
        acc_y_d = acc_y_q + ACC_W'(step_y_q);
        line_d  = line_q + INT_BITS'(1);
      end else begin
        acc_x_d = acc_x_q + ACC_W'(step_x_q);
        col_d   = col_q + INT_BITS'(1);
      end
    end
  end

  // Output comb: next beat is derived from next-state values so every output
  // can be registered; an unaccepted beat recomputes to the same fields.
  always_comb begin
    x_coord  = clamp_coord(acc_x_d, src_w_d);
    y_coord  = clamp_coord(acc_y_d, src_h_d);
    valid_d  = (state_d == RUN);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FIN);
    x_int_d  = x_coord[STEP_W-1:FRAC_BITS];
    x_frac_d = x_coord[FRAC_BITS-1:0];
    y_int_d  = y_coord[STEP_W-1:FRAC_BITS];
    y_frac_d = y_coord[FRAC_BITS-1:0];
    sol_d    = valid_d && (col_d == '0);
    eol_d    = valid_d && (col_d == out_w_d - INT_BITS'(1));
    eof_d    = eol_d && (line_d == out_h_d - INT_BITS'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_x_q <= '0;
      step_y_q <= '0;
      src_w_q  <= '0;
      src_h_q  <= '0;
      out_w_q  <= '0;
      out_h_q  <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      col_q    <= '0;
      line_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_int_q  <= '0;
      x_frac_q <= '0;
      y_int_q  <= '0;
      y_frac_q <= '0;
      sol_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      src_w_q  <= src_w_d;
      src_h_q  <= src_h_d;
      out_w_q  <= out_w_d;
      out_h_q  <= out_h_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      col_q    <= col_d;
      line_q   <= line_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x_int_q  <= x_int_d;
      x_frac_q <= x_frac_d;
      y_int_q  <= y_int_d;
      y_frac_q <= y_frac_d;
      sol_q    <= sol_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign done      = done_q;
  assign x_int     = x_int_q;
  assign x_frac    = x_frac_q;
  assign y_int     = y_int_q;
  assign y_frac    = y_frac_q;
  assign sol       = sol_q;
  assign eol       = eol_q;
  assign eof       = eof_q;

endmodule

// File: tb/tb_scale_coord_gen.sv
// Scoreboard bench for scale_coord_gen: expected beats are computed from
// column/line products and compared on each accepted beat.
module tb_scale_coord_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [27:0] step_x = '0, step_y = '0;
  logic [11:0] src_w = '0, src_h = '0, out_w = '0, out_h = '0;
  logic        busy, out_valid, sol, eol, eof, done;
  logic [11:0] x_int, y_int;
  logic [15:0] x_frac, y_frac;

  scale_coord_gen #(.INT_BITS(12), .FRAC_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .step_x(step_x), .step_y(step_y),
    .src_w(src_w), .src_h(src_h), .out_w(out_w), .out_h(out_h),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .x_int(x_int), .x_frac(x_frac), .y_int(y_int), .y_frac(y_frac),
    .sol(sol), .eol(eol), .eof(eof), .done(done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  int          beat_cnt = 0;
  int          stall_at = -1;
  int          stall_left = 0;
  int          done_cnt = 0;
  bit          eof_acc = 0;
  bit          held_v = 0;
  logic [63:0] held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_beat();
    return {5'b0, x_int, x_frac, y_int, y_frac, sol, eol, eof};
  endfunction

  function automatic logic [27:0] model_coord(input longint unsigned acc, input logic [11:0] sz);
    longint unsigned ip;
    ip = acc >> 16;
    if (sz == 12'd0) return 28'd0;
    if (ip >= longint'(sz) - 1) return {sz - 12'd1, 16'h0000};
    return {ip[11:0], acc[15:0]};
  endfunction

  task automatic push_frame(input logic [27:0] sx, sy, input logic [11:0] sw, sh, ow, oh);
    logic [27:0] xs, ys;
    bit          last_col;
    for (int ln = 0; ln < int'(oh); ln++) begin
      for (int c = 0; c < int'(ow); c++) begin
        xs = model_coord(longint'(c) * longint'(sx), sw);
        ys = model_coord(longint'(ln) * longint'(sy), sh);
        last_col = (c == int'(ow) - 1);
        exp_q.push_back({5'b0, xs, ys, c == 0, last_col, last_col && (ln == int'(oh) - 1)});
      end
    end
  endtask

  // Monitor: owns out_ready, pops the scoreboard on each acceptance.
  always @(negedge clk) begin
    if (!rst_n) begin
      out_ready = 1'b1;
      held_v    = 0;
      eof_acc   = 0;
    end else begin
      if (done) done_cnt++;
      if (eof_acc) begin
        check("done_after_eof", done, 1);
        eof_acc = 0;
      end
      if (held_v) begin
        check("stall_hold", {out_valid, dut_beat()}, {1'b1, held});
        held_v = 0;
      end
      if (out_valid) begin
        if (beat_cnt == stall_at && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", dut_beat(), 64'hDEAD);
          end else begin
            check("beat", dut_beat(), exp_q.pop_front());
          end
          beat_cnt++;
          if (eof) eof_acc = 1;
        end else begin
          held   = dut_beat();
          held_v = 1;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic run_frame(input logic [27:0] sx, sy, input logic [11:0] sw, sh, ow, oh,
                           input bit mid_start, input int stall_beat);
    int d0;
    @(negedge clk);
    step_x = sx; step_y = sy; src_w = sw; src_h = sh; out_w = ow; out_h = oh;
    push_frame(sx, sy, sw, sh, ow, oh);
    stall_at   = stall_beat;
    stall_left = 5;
    beat_cnt   = 0;
    d0         = done_cnt;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (ow != 0 && oh != 0) begin
      check("first_valid", out_valid, 1);
    end else begin
      check("empty_done", done, 1);
      check("empty_busy", busy, 1);
      check("empty_valid", out_valid, 0);
      @(negedge clk);
      check("empty_busy_drop", busy, 0);
    end
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && done_cnt != d0) break;
      @(negedge clk);
      if (mid_start && i == 3) begin
        start = 1'b1; step_x = 28'h1234; out_w = 12'd2; src_w = 12'd1;
      end
      if (mid_start && i == 4) start = 1'b0;
    end
    check("frame_done_cnt", done_cnt - d0, 1);
    check("beats_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    stall_at = -1;
  endtask

  initial begin
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fields", dut_beat(), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 2x down, then the same frame with beat 2 stalled for 5 cycles
    run_frame(28'h20000, 28'h20000, 12'd8, 12'd4, 12'd4, 12'd2, 0, -1);
    run_frame(28'h20000, 28'h20000, 12'd8, 12'd4, 12'd4, 12'd2, 0, 1);
    // x clamp at the right edge
    run_frame(28'h18000, 28'h10000, 12'd4, 12'd0, 12'd4, 12'd1, 0, -1);
    // upscale with fractional phases on both axes and y clamp
    run_frame(28'h0C000, 28'h0AAAB, 12'd3, 12'd2, 12'd5, 12'd3, 0, -1);
    // zero source size forces index and phase to 0; single-column frame
    run_frame(28'h10000, 28'h30000, 12'd0, 12'd0, 12'd1, 12'd3, 0, -1);
    // empty frames
    run_frame(28'h10000, 28'h10000, 12'd4, 12'd4, 12'd0, 12'd3, 0, -1);
    run_frame(28'h10000, 28'h10000, 12'd4, 12'd4, 12'd3, 12'd0, 0, -1);
    // start pulsed mid-frame is ignored
    run_frame(28'h14000, 28'h18000, 12'd6, 12'd5, 12'd4, 12'd3, 1, -1);

    // reset mid-frame, then restart from (0,0)
    @(negedge clk);
    step_x = 28'h20000; step_y = 28'h20000; src_w = 12'd8; src_h = 12'd4;
    out_w = 12'd4; out_h = 12'd2;
    push_frame(step_x, step_y, src_w, src_h, out_w, out_h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(28'h20000, 28'h20000, 12'd8, 12'd4, 12'd4, 12'd2, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
